// File: rtl/tsp_anneal_ctrl.sv
// Iteration controller for the TSP swap-improvement loop.
// Draws candidate position pairs from a free-running random word, hands each
// valid pair to the swap evaluator, and issues a commit pulse on acceptance.
// A run ends after an iteration budget or a run of consecutive rejections.
//
// Evaluator handshake: eval_go is a one-cycle launch pulse in ISSUE; the
// controller then sits in WAIT and samples eval_done (with eval_accept as its
// qualifier) only there. eval_v1/eval_v2 are held from ISSUE through COMMIT.
module tsp_anneal_ctrl #(
  parameter int N           = 64,
  parameter int IDX_W       = 6,
  parameter int MAX_ITER    = 100000,
  parameter int STALL_LIMIT = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [31:0]      rnd,
  output logic             eval_go,
  output logic [IDX_W-1:0] eval_v1,
  output logic [IDX_W-1:0] eval_v2,
  input  logic             eval_done,
  input  logic             eval_accept,
  output logic             commit,
  output logic             busy,
  output logic             done,
  output logic [31:0]      iter_cnt,
  output logic [31:0]      accept_cnt,
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PICK   = 3'd1,
    S_ISSUE  = 3'd2,
    S_WAIT   = 3'd3,
    S_COMMIT = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  localparam logic [31:0] MAX_ITER_C    = 32'(MAX_ITER);
  localparam logic [31:0] STALL_LIMIT_C = 32'(STALL_LIMIT);
  localparam logic [15:0] SPAN_C        = 16'(N - 2);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] eval_v1_q, eval_v1_d;
  logic [IDX_W-1:0] eval_v2_q, eval_v2_d;
  logic [31:0]      iter_cnt_q, iter_cnt_d;
  logic [31:0]      accept_cnt_q, accept_cnt_d;
  logic [31:0]      stall_cnt_q, stall_cnt_d;
  logic             done_q, done_d;

  logic [15:0]      a_mod, b_mod;
  logic [IDX_W-1:0] a_idx, b_idx, lo_idx, hi_idx;
  logic             pair_ok;
  logic [31:0]      iter_inc, accept_inc, stall_inc;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // End-of-run test applied to the counts as they will be after this cycle.
  function automatic logic term_hit(input logic [31:0] it, input logic [31:0] st);
    return (it == MAX_ITER_C) || (st == STALL_LIMIT_C);
  endfunction

  // Candidate pair: both positions in 1..N-2 (endpoints stay fixed), ordered,
  // and at least two apart so the swap touches four distinct edges.
  always_comb begin
    a_mod   = rnd[15:0] % SPAN_C;
    b_mod   = rnd[31:16] % SPAN_C;
    a_idx   = IDX_W'(a_mod) + IDX_W'(1);
    b_idx   = IDX_W'(b_mod) + IDX_W'(1);
    lo_idx  = (a_idx < b_idx) ? a_idx : b_idx;
    hi_idx  = (a_idx < b_idx) ? b_idx : a_idx;
    pair_ok = (hi_idx - lo_idx) >= IDX_W'(2);
  end

  // Next-state and counter update; abort overrides everything in busy states.
  always_comb begin
    state_d      = state_q;
    eval_v1_d    = eval_v1_q;
    eval_v2_d    = eval_v2_q;
    iter_cnt_d   = iter_cnt_q;
    accept_cnt_d = accept_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    done_d       = done_q;
    iter_inc     = sat_inc(iter_cnt_q);
    accept_inc   = sat_inc(accept_cnt_q);
    stall_inc    = sat_inc(stall_cnt_q);

    case (state_q)
      S_IDLE, S_DONE: begin
        if (!abort && start) begin
          iter_cnt_d   = '0;
          accept_cnt_d = '0;
          stall_cnt_d  = '0;
          done_d       = 1'b0;
          state_d      = S_PICK;
        end
      end
      S_PICK: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (pair_ok) begin
          eval_v1_d = lo_idx;
          eval_v2_d = hi_idx;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = abort ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        if (abort) begin
          // The verdict arriving with abort is dropped, so no commit follows.
          state_d = S_IDLE;
        end else if (eval_done) begin
          if (eval_accept) begin
            state_d = S_COMMIT;
          end else begin
            iter_cnt_d  = iter_inc;
            stall_cnt_d = stall_inc;
            if (term_hit(iter_inc, stall_inc)) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = S_PICK;
            end
          end
        end
      end
      S_COMMIT: begin
        if (abort) begin
          // Counts freeze; the commit pulse of this cycle is already visible.
          state_d = S_IDLE;
        end else begin
          accept_cnt_d = accept_inc;
          iter_cnt_d   = iter_inc;
          stall_cnt_d  = '0;
          if (term_hit(iter_inc, 32'd0)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_PICK;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      eval_v1_q    <= '0;
      eval_v2_q    <= '0;
      iter_cnt_q   <= '0;
      accept_cnt_q <= '0;
      stall_cnt_q  <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      eval_v1_q    <= eval_v1_d;
      eval_v2_q    <= eval_v2_d;
      iter_cnt_q   <= iter_cnt_d;
      accept_cnt_q <= accept_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
      done_q       <= done_d;
    end
  end

  // Moore outputs decoded from the state register only.
  always_comb begin
    eval_go    = (state_q == S_ISSUE);
    commit     = (state_q == S_COMMIT);
    busy       = (state_q != S_IDLE) && (state_q != S_DONE);
    done       = done_q;
    eval_v1    = eval_v1_q;
    eval_v2    = eval_v2_q;
    iter_cnt   = iter_cnt_q;
    accept_cnt = accept_cnt_q;
    state_dbg  = state_q;
  end

endmodule

// File: tb/tb_tsp_anneal_ctrl.sv
// Directed bench for tsp_anneal_ctrl: evaluator model driven from tasks,
// eval_go/commit events checked against an expected-event queue.
module tb_tsp_anneal_ctrl;

  localparam int IDX_W = 6;
  localparam logic [1:0] K_GO = 2'd1;
  localparam logic [1:0] K_CM = 2'd2;
  localparam logic [31:0] RND_BAD = 32'h0005_0005;
  localparam logic [31:0] RND_A   = 32'h0014_000A;

  logic             clk = 1'b0;
  logic             rst;
  logic             start, abort, eval_done, eval_accept;
  logic [31:0]      rnd;
  logic             eval_go, commit, busy, done;
  logic [IDX_W-1:0] eval_v1, eval_v2;
  logic [31:0]      iter_cnt, accept_cnt;
  logic [2:0]       state_dbg;

  int total = 0;
  int bad   = 0;
  logic [13:0] exp_q[$];

  tsp_anneal_ctrl #(.N(64), .IDX_W(IDX_W), .MAX_ITER(8), .STALL_LIMIT(3)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .rnd(rnd),
    .eval_go(eval_go), .eval_v1(eval_v1), .eval_v2(eval_v2),
    .eval_done(eval_done), .eval_accept(eval_accept), .commit(commit),
    .busy(busy), .done(done), .iter_cnt(iter_cnt), .accept_cnt(accept_cnt),
    .state_dbg(state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  function automatic logic [13:0] ev(input logic [1:0] k, input int a, input int b);
    return {k, 6'(a), 6'(b)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic wait_go(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (eval_go) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // Evaluator model: called in the ISSUE cycle, answers dly cycles later.
  task automatic respond(input int dly, input logic acc);
    repeat (dly) tick();
    eval_done   = 1'b1;
    eval_accept = acc;
    tick();
    eval_done   = 1'b0;
    eval_accept = 1'b0;
  endtask

  // Monitor: every eval_go / commit must match the next expected event.
  always @(negedge clk) begin
    logic [13:0] obs;
    if (!rst && (eval_go || commit)) begin
      obs = {(eval_go ? K_GO : K_CM), eval_v1, eval_v2};
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: got %0h expected none", obs);
      end else begin
        check("sb_event", 32'(obs), 32'(exp_q.pop_front()));
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    rst = 1'b1; start = 1'b0; abort = 1'b0; eval_done = 1'b0; eval_accept = 1'b0;
    rnd = RND_BAD;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_go", 32'(eval_go), 0);
    check("rst_iter", iter_cnt, 0);
    rst = 1'b0;
    tick();

    // Basic accept: pair (11,21), go latency 2, commit the cycle after done.
    exp_q.push_back(ev(K_GO, 11, 21));
    exp_q.push_back(ev(K_CM, 11, 21));
    rnd = RND_A;
    do_start();
    check("t1_go_early", 32'(eval_go), 0);
    check("t1_busy", 32'(busy), 1);
    tick();
    check("t1_go_lat", 32'(eval_go), 1);
    rnd = RND_BAD;
    respond(3, 1'b1);
    check("t1_commit_lat", 32'(commit), 1);
    tick();
    check("t1_commit_off", 32'(commit), 0);
    check("t1_iter", iter_cnt, 1);
    check("t1_acc", accept_cnt, 1);
    do_abort();
    check("t1_abort_busy", 32'(busy), 0);
    check("t1_abort_done", 32'(done), 0);

    // Invalid pair retries, then (1,49).
    rnd = RND_BAD;
    do_start();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t2_no_go", 32'(eval_go), 0);
    end
    exp_q.push_back(ev(K_GO, 1, 49));
    rnd = 32'h0000_0030;
    tick();
    check("t2_go", 32'(eval_go), 1);
    check("t2_v1", 32'(eval_v1), 1);
    check("t2_v2", 32'(eval_v2), 49);
    rnd = RND_BAD;
    respond(1, 1'b0);
    check("t2_iter", iter_cnt, 1);
    do_abort();

    // Stall stop after three rejections.
    rnd = RND_A;
    do_start();
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(ev(K_GO, 11, 21));
      wait_go(10, ok);
      check("t3_go_seen", 32'(ok), 1);
      respond(1, 1'b0);
    end
    check("t3_done", 32'(done), 1);
    check("t3_busy", 32'(busy), 0);
    check("t3_iter", iter_cnt, 3);
    check("t3_acc", accept_cnt, 0);
    tick();

    // Budget stop: accept/reject alternating, 8 evaluations.
    do_start();
    check("t4_clr_done", 32'(done), 0);
    check("t4_clr_iter", iter_cnt, 0);
    check("t4_clr_acc", accept_cnt, 0);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(ev(K_GO, 11, 21));
      if (i % 2 == 0) exp_q.push_back(ev(K_CM, 11, 21));
      wait_go(10, ok);
      check("t4_go_seen", 32'(ok), 1);
      if (i % 2 == 0) begin
        respond(2, 1'b1);
        tick();
      end else begin
        respond(2, 1'b0);
      end
      check("t4_iter", iter_cnt, 32'(i + 1));
      check("t4_done", 32'(done), (i == 7) ? 32'd1 : 32'd0);
    end
    check("t4_acc", accept_cnt, 4);
    rnd = RND_BAD;
    repeat (3) tick();
    check("t4_done_held", 32'(done), 1);
    check("t4_idle_busy", 32'(busy), 0);
    do_start();
    check("t4_restart_done", 32'(done), 0);
    check("t4_restart_iter", iter_cnt, 0);
    check("t4_restart_acc", accept_cnt, 0);
    do_abort();

    // Abort racing an accepting eval_done.
    rnd = RND_A;
    do_start();
    exp_q.push_back(ev(K_GO, 11, 21));
    wait_go(10, ok);
    check("t5_go_seen", 32'(ok), 1);
    rnd = RND_BAD;
    tick();
    eval_done = 1'b1; eval_accept = 1'b1; abort = 1'b1;
    tick();
    eval_done = 1'b0; eval_accept = 1'b0; abort = 1'b0;
    check("t5_busy", 32'(busy), 0);
    check("t5_commit", 32'(commit), 0);
    check("t5_done", 32'(done), 0);
    check("t5_iter", iter_cnt, 0);
    tick();
    check("t5_commit_late", 32'(commit), 0);

    // Asynchronous reset while waiting on the evaluator.
    rnd = RND_A;
    do_start();
    exp_q.push_back(ev(K_GO, 11, 21));
    wait_go(10, ok);
    check("t6_go1_seen", 32'(ok), 1);
    respond(1, 1'b0);
    exp_q.push_back(ev(K_GO, 11, 21));
    wait_go(10, ok);
    check("t6_go2_seen", 32'(ok), 1);
    rnd = RND_BAD;
    tick();
    check("t6_pre_iter", iter_cnt, 1);
    #3 rst = 1'b1;
    #1;
    check("t6_busy", 32'(busy), 0);
    check("t6_go", 32'(eval_go), 0);
    check("t6_commit", 32'(commit), 0);
    check("t6_done", 32'(done), 0);
    check("t6_v1", 32'(eval_v1), 0);
    check("t6_v2", 32'(eval_v2), 0);
    check("t6_iter", iter_cnt, 0);
    check("t6_acc", accept_cnt, 0);
    #2 rst = 1'b0;
    tick();
    eval_done = 1'b1; eval_accept = 1'b1;
    tick();
    eval_done = 1'b0; eval_accept = 1'b0;
    check("t6_late_busy", 32'(busy), 0);
    check("t6_late_commit", 32'(commit), 0);
    tick();
    check("t6_late_iter", iter_cnt, 0);
    check("t6_late_commit2", 32'(commit), 0);

    repeat (2) tick();
    check("sb_drain", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
